sprite_render: RTL and testbench

- Pixel-pipeline stage directly upstream of the sprite ROM; drives the ROM address and consumes its 4-bit registered pixel.
- Per screen pixel coming from the VGA timing generator, it:
  - decides whether the pixel lies inside the 16x16 sprite box;
  - builds the ROM address from the sprite index, row and column;
  - aligns the returned colour index with a delayed hit flag.
- Handles per-frame position latching (no tearing) and a two-frame walk animation. Output feeds the screen colour mixer.

---
 rtl/sprite_pkg.sv | 16 +
 rtl/sprite_anim_ctr.sv | 28 ++
 rtl/sprite_render.sv | 84 ++++++++
 tb/tb_sprite_render.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants for the sprite rendering slice: default geometry,
// ROM address width, direction encoding and the transparent colour.
package sprite_pkg;

    localparam int SPR_W_DEF = 16;
    localparam int SPR_H_DEF = 16;
    localparam int ROM_AW    = 11;

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_UP    = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd3;

    localparam logic [3:0] TRANSP_DEF = 4'h0;

endpackage

// File: rtl/sprite_anim_ctr.sv
// Walk-animation timer: counts frame_start pulses and flips the anim bit
// every ANIM_FRAMES frames.
module sprite_anim_ctr #(
    parameter int ANIM_FRAMES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start,
    output logic anim
);

    logic [7:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= 8'd0;
            anim      <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == 8'(ANIM_FRAMES - 1)) begin
                frame_cnt <= 8'd0;
                anim      <= ~anim;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/sprite_render.sv
// Sprite pixel pipeline: hit test against the frame-latched position, ROM
// address generation, and hit/colour alignment with the registered ROM.
module sprite_render
    import sprite_pkg::*;
#(
    parameter int         SPR_W       = SPR_W_DEF,
    parameter int         SPR_H       = SPR_H_DEF,
    parameter int         ANIM_FRAMES = 8,
    parameter logic [3:0] TRANSP      = TRANSP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [9:0]        px,
    input  logic [9:0]        py,
    input  logic              active,
    input  logic [9:0]        spr_x,
    input  logic [9:0]        spr_y,
    input  logic [1:0]        spr_dir,
    output logic [ROM_AW-1:0] rom_add,
    input  logic [3:0]        rom_pixel,
    output logic              pix_on,
    output logic [3:0]        pix_color
);

    logic [9:0]  sx;
    logic [9:0]  sy;
    logic [1:0]  sdir;
    logic        anim;
    logic [10:0] dx;
    logic [10:0] dy;
    logic        hit0;
    logic        hit1;
    logic        hit2;
    logic        pix_on_next;

    sprite_anim_ctr #(
        .ANIM_FRAMES (ANIM_FRAMES)
    ) u_anim (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .anim        (anim)
    );

    // Position only moves at frame_start so a frame never shows two positions.
    always_ff @(posedge clk) begin
        if (rst) begin
            sx   <= 10'd0;
            sy   <= 10'd0;
            sdir <= DIR_RIGHT;
        end else if (frame_start) begin
            sx   <= spr_x;
            sy   <= spr_y;
            sdir <= spr_dir;
        end
    end

    // Bit 10 set means the pixel is left of / above the sprite; no wrap-around.
    always_comb begin
        dx   = {1'b0, px} - {1'b0, sx};
        dy   = {1'b0, py} - {1'b0, sy};
        hit0 = active & ~dx[10] & (dx < 11'(SPR_W))
                      & ~dy[10] & (dy < 11'(SPR_H));
        pix_on_next = hit2 & (rom_pixel != TRANSP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_add   <= '0;
            hit1      <= 1'b0;
            hit2      <= 1'b0;
            pix_on    <= 1'b0;
            pix_color <= 4'h0;
        end else begin
            rom_add   <= {sdir, anim, dy[3:0], dx[3:0]};
            hit1      <= hit0;
            hit2      <= hit1;
            pix_on    <= pix_on_next;
            pix_color <= pix_on_next ? rom_pixel : 4'h0;
        end
    end

endmodule

// File: tb/tb_sprite_render.sv
// Directed bench for sprite_render with a registered sprite ROM model.
module tb_sprite_render;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [9:0]  px;
    logic [9:0]  py;
    logic        active;
    logic [9:0]  spr_x;
    logic [9:0]  spr_y;
    logic [1:0]  spr_dir;
    logic [10:0] rom_add;
    logic [3:0]  rom_pixel;
    logic        pix_on;
    logic [3:0]  pix_color;

    logic [3:0]  rom_mem [0:2047];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_pixel <= rom_mem[rom_add];

    sprite_render dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .px          (px),
        .py          (py),
        .active      (active),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .spr_dir     (spr_dir),
        .rom_add     (rom_add),
        .rom_pixel   (rom_pixel),
        .pix_on      (pix_on),
        .pix_color   (pix_color)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y,
                                 input logic act, input logic fs);
        px          = x;
        py          = y;
        active      = act;
        frame_start = fs;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One isolated pixel: address checked one cycle later, output three cycles later.
    task automatic checkPixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                              input logic act, input logic [10:0] exp_add,
                              input logic exp_on, input logic [3:0] exp_col);
        applyStimulus(x, y, act, 1'b0);
        tick();
        checkOutput({tag, "_add"}, 32'(rom_add), 32'(exp_add));
        applyStimulus(10'd0, 10'd0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput({tag, "_on"}, 32'(pix_on), 32'(exp_on));
        checkOutput({tag, "_col"}, 32'(pix_color), 32'(exp_col));
    endtask

    task automatic doFrame(input logic [9:0] x, input logic [9:0] y, input logic [1:0] d);
        spr_x   = x;
        spr_y   = y;
        spr_dir = d;
        applyStimulus(10'd0, 10'd0, 1'b0, 1'b1);
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom_mem[i] = 4'hF;
        rom_mem[11'h035] = 4'h7;
        rom_mem[11'h0FF] = 4'hA;
        rom_mem[11'h012] = 4'h0;
        rom_mem[11'h635] = 4'h9;

        rst     = 1'b1;
        spr_x   = 10'd100;
        spr_y   = 10'd50;
        spr_dir = 2'd0;
        applyStimulus(10'd0, 10'd0, 1'b0, 1'b0);

        // Reset held with frame_start and pixels toggling.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(10'(100 + i), 10'd53, 1'b1, i[0]);
            tick();
            checkOutput("rst_add", 32'(rom_add), 32'h0);
            checkOutput("rst_on", 32'(pix_on), 32'h0);
            checkOutput("rst_col", 32'(pix_color), 32'h0);
        end
        rst = 1'b0;
        applyStimulus(10'd0, 10'd0, 1'b0, 1'b0);

        // Shadows at 0,0 and anim 0 after reset.
        checkPixel("post_rst", 10'd5, 10'd3, 1'b1, 11'h035, 1'b1, 4'h7);

        // Latch and latency (frame 1).
        doFrame(10'd100, 10'd50, 2'd0);
        checkPixel("latch", 10'd105, 10'd53, 1'b1, 11'h035, 1'b1, 4'h7);

        // Box edges.
        checkPixel("left_out", 10'd99, 10'd53, 1'b1, 11'h03F, 1'b0, 4'h0);
        checkPixel("right_out", 10'd116, 10'd53, 1'b1, 11'h030, 1'b0, 4'h0);
        checkPixel("corner", 10'd115, 10'd65, 1'b1, 11'h0FF, 1'b1, 4'hA);
        checkPixel("below_out", 10'd105, 10'd66, 1'b1, 11'h005, 1'b0, 4'h0);
        checkPixel("above_out", 10'd105, 10'd49, 1'b1, 11'h0F5, 1'b0, 4'h0);

        // Right screen edge, no wrap (frame 2).
        doFrame(10'd1020, 10'd50, 2'd0);
        checkPixel("edge_hit", 10'd1023, 10'd50, 1'b1, 11'h003, 1'b1, 4'hF);
        checkPixel("nowrap", 10'd3, 10'd50, 1'b1, 11'h007, 1'b0, 4'h0);

        // Transparency and inactive (frame 3).
        doFrame(10'd100, 10'd50, 2'd0);
        checkPixel("transp", 10'd102, 10'd51, 1'b1, 11'h012, 1'b0, 4'h0);
        checkPixel("inactive", 10'd105, 10'd53, 1'b0, 11'h035, 1'b0, 4'h0);

        // Frames 4..7: anim still 0; frame 8 toggles it.
        for (int i = 0; i < 4; i++) doFrame(10'd100, 10'd50, 2'd0);
        checkPixel("anim_f7", 10'd105, 10'd53, 1'b1, 11'h035, 1'b1, 4'h7);
        doFrame(10'd100, 10'd50, 2'd0);
        checkPixel("anim_f8", 10'd105, 10'd53, 1'b1, 11'h135, 1'b1, 4'hF);

        // Frames 9..15 keep anim 1; frame 16 clears it.
        for (int i = 0; i < 7; i++) doFrame(10'd100, 10'd50, 2'd0);
        checkPixel("anim_f15", 10'd105, 10'd53, 1'b1, 11'h135, 1'b1, 4'hF);
        doFrame(10'd100, 10'd50, 2'd0);
        checkPixel("anim_f16", 10'd105, 10'd53, 1'b1, 11'h035, 1'b1, 4'h7);

        // Direction down (frame 17).
        doFrame(10'd100, 10'd50, 2'd3);
        checkPixel("dir_down", 10'd105, 10'd53, 1'b1, 11'h635, 1'b1, 4'h9);

        // Same-cycle latch (frame 18): old x=100 then new x=200, streamed.
        spr_x   = 10'd200;
        spr_y   = 10'd50;
        spr_dir = 2'd3;
        applyStimulus(10'd105, 10'd53, 1'b1, 1'b1);
        tick();
        checkOutput("same_old_add", 32'(rom_add), 32'h635);
        applyStimulus(10'd205, 10'd53, 1'b1, 1'b0);
        tick();
        checkOutput("same_new_add", 32'(rom_add), 32'h635);
        applyStimulus(10'd105, 10'd53, 1'b1, 1'b0);
        tick();
        checkOutput("same_old_on", 32'(pix_on), 32'h1);
        checkOutput("same_old_col", 32'(pix_color), 32'h9);
        applyStimulus(10'd0, 10'd0, 1'b0, 1'b0);
        tick();
        checkOutput("same_new_on", 32'(pix_on), 32'h1);
        checkOutput("same_new_col", 32'(pix_color), 32'h9);
        tick();
        checkOutput("stale_x_on", 32'(pix_on), 32'h0);
        checkOutput("stale_x_col", 32'(pix_color), 32'h0);

        // Reset mid-stream flushes in-flight hits.
        applyStimulus(10'd205, 10'd53, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        applyStimulus(10'd0, 10'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        checkOutput("flush_on", 32'(pix_on), 32'h0);
        checkOutput("flush_col", 32'(pix_color), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
